// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: edge-triggered fetch from a synchronous instruction
// memory into the IR, with PC advance, jumps and a sticky halt.
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               end_process,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [5:0]         instruction_opcode,
    output logic [INSTR_W-7:0] operand,
    output logic               ir_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   jump_addr_pend;
    logic                jump_pend;
    logic                fetch_q;
    logic                fetch_edge;
    logic [INSTR_W-1:0]  ir;

    assign fetch_edge         = fetch & ~fetch_q;
    assign imem_addr          = pc;
    assign imem_rd            = (state == READ);
    assign instruction_opcode = ir[INSTR_W-1:INSTR_W-6];
    assign operand            = ir[INSTR_W-7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // end_process wins over every other transition, so a LOAD in flight never completes
    always_comb begin
        state_next = state;
        if (end_process) begin
            state_next = HALT;
        end else begin
            case (state)
                IDLE:    if (fetch_edge) state_next = READ;
                READ:    state_next = LOAD;
                LOAD:    state_next = IDLE;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= '0;
            ir             <= '0;
            ir_valid       <= 1'b0;
            halted         <= 1'b0;
            fetch_count    <= 16'd0;
            fetch_q        <= 1'b0;
            jump_pend      <= 1'b0;
            jump_addr_pend <= '0;
        end else begin
            fetch_q <= fetch;
            halted  <= (state_next == HALT);
            if (!end_process) begin
                case (state)
                    IDLE: begin
                        if (jump) pc <= jump_addr;
                    end
                    READ: begin
                        if (jump) begin
                            jump_pend      <= 1'b1;
                            jump_addr_pend <= jump_addr;
                        end
                    end
                    LOAD: begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
                        // a jump arriving in LOAD itself is newer than any pending one
                        if (jump)           pc <= jump_addr;
                        else if (jump_pend) pc <= jump_addr_pend;
                        else                pc <= pc + PC_ONE;
                        jump_pend <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous memory model and an
// expected-result queue filled at each fetch request.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        end_process;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [23:0] imem_rdata = 24'd0;
    logic [5:0]  instruction_opcode;
    logic [17:0] operand;
    logic        ir_valid;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct {
        logic [23:0] word;
        logic [7:0]  next_pc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          rd_cnt;
    logic [7:0]  pc_m;
    logic [23:0] ir_m;
    logic [15:0] cnt_m;
    logic        iv_m;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(24)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch              (fetch),
        .jump               (jump),
        .jump_addr          (jump_addr),
        .end_process        (end_process),
        .imem_addr          (imem_addr),
        .imem_rd            (imem_rd),
        .imem_rdata         (imem_rdata),
        .instruction_opcode (instruction_opcode),
        .operand            (operand),
        .ir_valid           (ir_valid),
        .halted             (halted),
        .fetch_count        (fetch_count)
    );

    always #5 clk = ~clk;

    // Word 0..3 carry opcodes 1..4; the operand makes every address distinct
    function automatic logic [23:0] mem_word(input logic [7:0] a);
        logic [5:0]  op;
        logic [17:0] opnd;
        op   = a[5:0] + 6'd1;
        opnd = {a, 10'h2A5} ^ 18'h15A3C;
        return {op, opnd};
    endfunction

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem_word(imem_addr);
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout reached before end of sequence");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_model();
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    endtask

    // One fetch request, optionally with a jump in the IDLE, READ or LOAD cycle
    task automatic apply_stimulus(input logic j_idle, input logic j_read, input logic j_load,
                                  input logic [7:0] ja);
        exp_t       e;
        logic [7:0] ra;
        ra        = j_idle ? ja : pc_m;
        e.word    = mem_word(ra);
        e.next_pc = (j_read | j_load) ? ja : ra + 8'd1;
        sb.push_back(e);
        fetch     = 1'b1;
        jump      = j_idle;
        jump_addr = ja;
        tick();
        check_output("read_rd", imem_rd, 1);
        check_output("read_addr", imem_addr, ra);
        fetch = 1'b0;
        jump  = j_read;
        tick();
        check_output("load_ir_valid", ir_valid, iv_m);
        jump = j_load;
        tick();
        jump = 1'b0;
        e = sb.pop_front();
        pc_m = e.next_pc;
        ir_m = e.word;
        iv_m = 1'b1;
        count_model();
        check_output("opcode", instruction_opcode, e.word[23:18]);
        check_output("operand", operand, e.word[17:0]);
        check_output("pc", imem_addr, e.next_pc);
        check_output("ir_valid", ir_valid, 1);
        check_output("idle_rd", imem_rd, 0);
        check_output("fetch_count", fetch_count, cnt_m);
    endtask

    task automatic jump_only(input logic [7:0] ja);
        jump      = 1'b1;
        jump_addr = ja;
        tick();
        jump = 1'b0;
        pc_m = ja;
        check_output("jump_pc", imem_addr, ja);
        check_output("jump_rd", imem_rd, 0);
        check_output("jump_count", fetch_count, cnt_m);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_opcode"}, instruction_opcode, 0);
        check_output({tag, "_operand"}, operand, 0);
        check_output({tag, "_pc"}, imem_addr, 0);
        check_output({tag, "_ir_valid"}, ir_valid, 0);
        check_output({tag, "_halted"}, halted, 0);
        check_output({tag, "_rd"}, imem_rd, 0);
        check_output({tag, "_count"}, fetch_count, 0);
    endtask

    task automatic model_reset();
        pc_m  = 8'd0;
        ir_m  = 24'd0;
        cnt_m = 16'd0;
        iv_m  = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        fetch       = 1'b0;
        jump        = 1'b0;
        jump_addr   = 8'd0;
        end_process = 1'b0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Sequential fetch of words 0..3
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0);
        check_output("seq_count", fetch_count, 4);
        check_output("seq_pc", imem_addr, 4);

        // Jumps: with the fetch, during READ, during LOAD
        jump_only(8'd2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h40);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h40);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h10);

        // Strobe held high for 10 cycles: one access only
        rd_cnt = 0;
        fetch  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        ir_m = mem_word(pc_m);
        pc_m = pc_m + 8'd1;
        count_model();
        check_output("held_reads", rd_cnt, 1);
        check_output("held_opcode", instruction_opcode, ir_m[23:18]);
        check_output("held_operand", operand, ir_m[17:0]);
        check_output("held_pc", imem_addr, pc_m);
        check_output("held_count", fetch_count, cnt_m);

        // New edge while the previous access is still in flight is dropped
        rd_cnt = 0;
        fetch  = 1'b1;
        tick();
        if (imem_rd) rd_cnt++;
        fetch = 1'b0;
        tick();
        fetch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        fetch = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        ir_m = mem_word(pc_m);
        pc_m = pc_m + 8'd1;
        count_model();
        check_output("overlap_reads", rd_cnt, 1);
        check_output("overlap_operand", operand, ir_m[17:0]);
        check_output("overlap_pc", imem_addr, pc_m);
        check_output("overlap_count", fetch_count, cnt_m);

        // PC wrap from 0xFF
        jump_only(8'hFF);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0);
        check_output("wrap_pc", imem_addr, 0);

        // Halt requested in READ
        fetch = 1'b1;
        tick();
        check_output("halt_read_rd", imem_rd, 1);
        fetch       = 1'b0;
        end_process = 1'b1;
        tick();
        end_process = 1'b0;
        check_output("halt_halted", halted, 1);
        check_output("halt_rd", imem_rd, 0);
        check_output("halt_operand", operand, ir_m[17:0]);
        check_output("halt_count", fetch_count, cnt_m);
        check_output("halt_pc", imem_addr, pc_m);
        rd_cnt    = 0;
        fetch     = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h55;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        fetch = 1'b0;
        jump  = 1'b0;
        tick();
        fetch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_rd) rd_cnt++;
        end
        fetch = 1'b0;
        check_output("halted_reads", rd_cnt, 0);
        check_output("halted_stays", halted, 1);
        check_output("halted_pc", imem_addr, pc_m);
        check_output("halted_operand", operand, ir_m[17:0]);
        check_output("halted_count", fetch_count, cnt_m);

        // Reset leaves HALT; a fetch then reads address 0
        rst = 1'b0;
        #1;
        check_reset_state("halt_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0);

        // Reset asserted in the middle of LOAD
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("load_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0);
        check_output("post_reset_opcode", instruction_opcode, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
